regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
//  Parametrised integer register file for the RV32I core, successor to the fixed 32x32 file.
//  Configurable width/depth, optional hardwired-zero entry, optional write-to-read bypass.
//  Built-in sequential clear engine zeroes every entry after reset or on request.
//  Sits between decode (read addresses) and writeback (write port).
// PARAMETERS
//  DATA_W    32  bits per register
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
//  ZERO_REG  1   1: entry 0 always reads 0 and ignores writes; 0: entry 0 is ordinary
//  BYPASS    1   1: same-cycle write data forwarded to a matching read port; 0: no forwarding
// PORTS
//  clk         in   1       clock, all state updates on rising edge
//  rst         in   1       synchronous, active-high reset
//  clear_req   in   1       pulse: restart clear sequence (soft flush)
//  reg_write   in   1       write enable
//  rd          in   ADDR_W  write address
//  write_data  in   DATA_W  write data
//  rs1         in   ADDR_W  read port 1 address
//  rs2         in   ADDR_W  read port 2 address
//  read_data1  out  DATA_W  read port 1 data (combinational)
//  read_data2  out  DATA_W  read port 2 data (combinational)
//  ready       out  1       1 = clear done, writes accepted
//  wr_dropped  out  1       registered: 1 for one cycle after a write was discarded
// BEHAVIOUR
//  FSM states: CLEAR, READY. clr_idx counter ADDR_W bits.
//  rst=1 at edge: state<=CLEAR, clr_idx<=0, wr_dropped<=0; ready=0 next cycle. Entry contents not
//   required to change on the reset edge itself.
//  CLEAR: each cycle writes 0 to entry clr_idx, clr_idx++. At clr_idx==DEPTH-1 writes last entry
//   and goes READY. Full clear takes DEPTH cycles after rst deasserts; ready=1 from cycle DEPTH.
//  CLEAR: reg_write ignored; if reg_write=1 then wr_dropped<=1 next cycle. read_data1/2 = 0.
//  CLEAR: clear_req ignored (sequence continues, no restart).
//  READY: clear_req=1 -> state<=CLEAR, clr_idx<=0; concurrent write dropped (clear wins),
//   wr_dropped<=1 if reg_write=1.
//  READY write: reg_write=1 -> entry rd <= write_data at edge; if ZERO_REG=1 and rd==0, no update,
//   not counted as dropped.
//  Reads (READY): read_dataN = entry[rsN]; if ZERO_REG=1 and rsN==0 -> 0.
//  Bypass (BYPASS=1, READY): reg_write=1 and rd==rsN and not (ZERO_REG and rd==0) and no clear_req
//   -> read_dataN = write_data same cycle. Both ports bypass independently.
//  BYPASS=0: reads return pre-edge content; new value visible the cycle after the write.
//  rst has priority over clear_req and writes; rst mid-CLEAR restarts at clr_idx=0.
//  wr_dropped is 0 in any cycle following a cycle with no discarded write.
//  No X on read ports after ready=1; all widths exact, no truncation.
// TESTING
//  rst 1 cycle, write 32'hDEAD_BEEF to rd=3 each cycle -> ready=0 for 32 cycles, wr_dropped=1,
//   reads 0; ready=1 at cycle 32; rs1=3 reads 0.
//  READY: write 32'h1234_5678 to rd=7, rs1=7 same cycle, BYPASS=1 -> read_data1=32'h1234_5678
//   immediately; BYPASS=0 -> old value (0) then 32'h1234_5678 next cycle.
//  ZERO_REG=1: write 32'hFFFF_FFFF to rd=0, rs1=rs2=0 -> both reads 0 that and next cycle,
//   wr_dropped=0.
//  Fill rd=1..31 with value=rd, then clear_req with write rd=5 data 9 -> wr_dropped=1,
//   ready=0 for 32 cycles, afterwards all entries read 0.
//  rst asserted at clear cycle 10 -> clear restarts, ready rises exactly 32 cycles after rst drops.
//  ADDR_W=3, DATA_W=16 instance: 8-cycle clear, write 16'hA5A5 to rd=7, rs2=7 reads 16'hA5A5.

Source files
------------

// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
//   Parametrised integer register file for the RV32I core. Two combinational
//   read ports and one write port. It can optionally hardwire entry 0 to zero
//   and can optionally forward same-cycle write data to the read ports.
//   A sequential clear engine zeroes one entry per cycle after reset or after
//   a clear request. Writes are accepted only once every entry has been cleared.
//
// Parameters
//   DATA_W    bits per register
//   ADDR_W    address width, DEPTH = 2**ADDR_W entries
//   ZERO_REG  1: entry 0 reads as zero and ignores writes
//   BYPASS    1: a write in the current cycle is forwarded to a matching read
//
// Ports
//   clk         in   clock, all state updates on the rising edge
//   rst         in   synchronous active-high reset
//   clear_req   in   restart the clear sequence (ignored while clearing)
//   reg_write   in   write enable
//   rd          in   write address
//   write_data  in   write data
//   rs1, rs2    in   read addresses
//   read_data1  out  read port 1 data (combinational)
//   read_data2  out  read port 2 data (combinational)
//   ready       out  1 once the clear sequence has finished
//   wr_dropped  out  registered, 1 for one cycle after a write was discarded
// -----------------------------------------------------------------------------
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              ready,
    output logic              wr_dropped
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_DAT = {DATA_W{1'b0}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] clr_idx_r;
    logic [ADDR_W-1:0] clr_idx_nxt_s;
    logic              wr_dropped_r;

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              in_clear_s;
    logic              rd_is_zero_s;
    logic              write_ok_s;
    logic              drop_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] rdata1_s;
    logic [DATA_W-1:0] rdata2_s;

    // Write qualification: a pending clear request beats a same-cycle write.
    always_comb begin
        in_clear_s   = (state_r == ST_CLEAR);
        rd_is_zero_s = ZERO_REG && (rd == ZERO_IDX);
        write_ok_s   = !in_clear_s && reg_write && !clear_req && !rd_is_zero_s;
        // Writes to the hardwired zero entry are silently ignored, not dropped.
        drop_s       = reg_write && (in_clear_s || clear_req);
    end

    // Next-state and clear-index logic for the clear engine.
    always_comb begin
        state_nxt_s   = state_r;
        clr_idx_nxt_s = clr_idx_r;
        case (state_r)
            ST_CLEAR: begin
                // The index wraps back to zero after the last entry.
                clr_idx_nxt_s = clr_idx_r + ADDR_W'(1'b1);
                if (clr_idx_r == LAST_IDX) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_READY: begin
                if (clear_req) begin
                    state_nxt_s   = ST_CLEAR;
                    clr_idx_nxt_s = ZERO_IDX;
                end else begin
                    state_nxt_s   = ST_READY;
                    clr_idx_nxt_s = clr_idx_r;
                end
            end
            default: begin
                state_nxt_s   = ST_CLEAR;
                clr_idx_nxt_s = ZERO_IDX;
            end
        endcase
    end

    // Storage write-port mux: the clear engine owns the port while clearing.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = rd;
        mem_wdata_s = write_data;
        if (in_clear_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_idx_r;
            mem_wdata_s = ZERO_DAT;
        end else if (write_ok_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = rd;
            mem_wdata_s = write_data;
        end else begin
            mem_we_s    = 1'b0;
            mem_waddr_s = rd;
            mem_wdata_s = write_data;
        end
    end

    // Read port 1: zero while clearing, then bypass, hardwired zero, storage.
    always_comb begin
        rdata1_s = ZERO_DAT;
        if (in_clear_s) begin
            rdata1_s = ZERO_DAT;
        end else if (BYPASS && write_ok_s && (rd == rs1)) begin
            rdata1_s = write_data;
        end else if (ZERO_REG && (rs1 == ZERO_IDX)) begin
            rdata1_s = ZERO_DAT;
        end else begin
            rdata1_s = mem_r[rs1];
        end
    end

    // Read port 2: same priority as port 1, forwarded independently.
    always_comb begin
        rdata2_s = ZERO_DAT;
        if (in_clear_s) begin
            rdata2_s = ZERO_DAT;
        end else if (BYPASS && write_ok_s && (rd == rs2)) begin
            rdata2_s = write_data;
        end else if (ZERO_REG && (rs2 == ZERO_IDX)) begin
            rdata2_s = ZERO_DAT;
        end else begin
            rdata2_s = mem_r[rs2];
        end
    end

    // Control registers; reset outranks clear requests and writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_CLEAR;
            clr_idx_r    <= ZERO_IDX;
            wr_dropped_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            clr_idx_r    <= clr_idx_nxt_s;
            wr_dropped_r <= drop_s;
        end
    end

    // Register storage; contents are left alone on the reset edge itself.
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign read_data1 = rdata1_s;
    assign read_data2 = rdata2_s;
    assign ready      = (state_r == ST_READY);
    assign wr_dropped = wr_dropped_r;

endmodule

// File: tb/tb_regfile_param.sv
// -----------------------------------------------------------------------------
// tb_regfile_param
//   Directed self-checking bench for regfile_param. Three instances are used:
//   the default 32x32 file with bypass, the same geometry without bypass, and
//   a small 8x16 file. Inputs change 1 time unit after a rising edge and
//   outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_regfile_param;

    logic        clk;
    logic        rst;
    logic        clear_req;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        ready;
    logic        wr_dropped;

    logic [31:0] nb_read_data1;
    logic [31:0] nb_read_data2;
    logic        nb_ready;
    logic        nb_wr_dropped;

    logic        s_clear_req;
    logic        s_reg_write;
    logic [2:0]  s_rd;
    logic [15:0] s_write_data;
    logic [2:0]  s_rs1;
    logic [2:0]  s_rs2;
    logic [15:0] s_read_data1;
    logic [15:0] s_read_data2;
    logic        s_ready;
    logic        s_wr_dropped;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_param dut (
        .clk(clk), .rst(rst), .clear_req(clear_req), .reg_write(reg_write),
        .rd(rd), .write_data(write_data), .rs1(rs1), .rs2(rs2),
        .read_data1(read_data1), .read_data2(read_data2),
        .ready(ready), .wr_dropped(wr_dropped)
    );

    regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .clear_req(clear_req), .reg_write(reg_write),
        .rd(rd), .write_data(write_data), .rs1(rs1), .rs2(rs2),
        .read_data1(nb_read_data1), .read_data2(nb_read_data2),
        .ready(nb_ready), .wr_dropped(nb_wr_dropped)
    );

    regfile_param #(.DATA_W(16), .ADDR_W(3)) dut_s (
        .clk(clk), .rst(rst), .clear_req(s_clear_req), .reg_write(s_reg_write),
        .rd(s_rd), .write_data(s_write_data), .rs1(s_rs1), .rs2(s_rs2),
        .read_data1(s_read_data1), .read_data2(s_read_data2),
        .ready(s_ready), .wr_dropped(s_wr_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        int cnt;
        rst = 1'b1; clear_req = 1'b0; reg_write = 1'b1; rd = 5'd3;
        write_data = 32'hDEAD_BEEF; rs1 = 5'd3; rs2 = 5'd3;
        s_clear_req = 1'b0; s_reg_write = 1'b0; s_rd = 3'd0;
        s_write_data = 16'h0000; s_rs1 = 3'd0; s_rs2 = 3'd0;
        @(posedge clk); #1;
        rst = 1'b0; #1;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
        n_checks++; if (wr_dropped !== 1'b0) begin n_fail++; $display("FAIL reset_wr_dropped: got %b expected 0", wr_dropped); end
        cnt = 0;
        while (!ready && cnt < 100) begin
            @(posedge clk); #2; cnt++;
            n_checks++; if (wr_dropped !== 1'b1) begin n_fail++; $display("FAIL clear_wr_dropped cyc %0d: got %b expected 1", cnt, wr_dropped); end
            if (!ready) begin
                n_checks++; if (read_data1 !== 32'h0) begin n_fail++; $display("FAIL clear_read1 cyc %0d: got %h expected 0", cnt, read_data1); end
            end
        end
        n_checks++; if (cnt !== 32) begin n_fail++; $display("FAIL reset_clear_len: got %0d expected 32", cnt); end
        reg_write = 1'b0; #1;
        n_checks++; if (read_data1 !== 32'h0) begin n_fail++; $display("FAIL reset_read_r3: got %h expected 0", read_data1); end
        n_checks++; if (nb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_nb_ready: got %b expected 1", nb_ready); end
        @(posedge clk); #1;
        n_checks++; if (wr_dropped !== 1'b0) begin n_fail++; $display("FAIL reset_wr_dropped_clr: got %b expected 0", wr_dropped); end
    endtask

    task automatic test_bypass;
        reg_write = 1'b1; rd = 5'd7; write_data = 32'h1234_5678; rs1 = 5'd7; rs2 = 5'd2; #1;
        n_checks++; if (read_data1 !== 32'h1234_5678) begin n_fail++; $display("FAIL bypass_rd1: got %h expected 12345678", read_data1); end
        n_checks++; if (nb_read_data1 !== 32'h0) begin n_fail++; $display("FAIL nobypass_rd1_old: got %h expected 0", nb_read_data1); end
        n_checks++; if (read_data2 !== 32'h0) begin n_fail++; $display("FAIL bypass_rd2_other: got %h expected 0", read_data2); end
        @(posedge clk); #1;
        reg_write = 1'b0; #1;
        n_checks++; if (nb_read_data1 !== 32'h1234_5678) begin n_fail++; $display("FAIL nobypass_rd1_new: got %h expected 12345678", nb_read_data1); end
        n_checks++; if (read_data1 !== 32'h1234_5678) begin n_fail++; $display("FAIL bypass_rd1_stored: got %h expected 12345678", read_data1); end
        reg_write = 1'b1; rd = 5'd2; write_data = 32'h0000_00AB; #1;
        n_checks++; if (read_data2 !== 32'h0000_00AB) begin n_fail++; $display("FAIL bypass_rd2: got %h expected 000000ab", read_data2); end
        n_checks++; if (read_data1 !== 32'h1234_5678) begin n_fail++; $display("FAIL bypass_rd1_indep: got %h expected 12345678", read_data1); end
        n_checks++; if (nb_read_data2 !== 32'h0) begin n_fail++; $display("FAIL nobypass_rd2_old: got %h expected 0", nb_read_data2); end
        @(posedge clk); #1;
        reg_write = 1'b0;
    endtask

    task automatic test_zero_reg;
        reg_write = 1'b1; rd = 5'd0; write_data = 32'hFFFF_FFFF; rs1 = 5'd0; rs2 = 5'd0; #1;
        n_checks++; if (read_data1 !== 32'h0) begin n_fail++; $display("FAIL zero_rd1_same: got %h expected 0", read_data1); end
        n_checks++; if (read_data2 !== 32'h0) begin n_fail++; $display("FAIL zero_rd2_same: got %h expected 0", read_data2); end
        @(posedge clk); #1;
        reg_write = 1'b0; #1;
        n_checks++; if (read_data1 !== 32'h0) begin n_fail++; $display("FAIL zero_rd1_next: got %h expected 0", read_data1); end
        n_checks++; if (read_data2 !== 32'h0) begin n_fail++; $display("FAIL zero_rd2_next: got %h expected 0", read_data2); end
        n_checks++; if (nb_read_data1 !== 32'h0) begin n_fail++; $display("FAIL zero_nb_rd1_next: got %h expected 0", nb_read_data1); end
        n_checks++; if (wr_dropped !== 1'b0) begin n_fail++; $display("FAIL zero_wr_dropped: got %b expected 0", wr_dropped); end
    endtask

    task automatic test_fill_clear;
        int cnt;
        for (int r = 1; r < 32; r++) begin
            reg_write = 1'b1; rd = 5'(r); write_data = 32'(r);
            @(posedge clk); #1;
        end
        reg_write = 1'b0; rs1 = 5'd5; rs2 = 5'd31; #1;
        n_checks++; if (read_data1 !== 32'd5) begin n_fail++; $display("FAIL fill_r5: got %h expected 5", read_data1); end
        n_checks++; if (read_data2 !== 32'd31) begin n_fail++; $display("FAIL fill_r31: got %h expected 31", read_data2); end
        n_checks++; if (nb_read_data2 !== 32'd31) begin n_fail++; $display("FAIL fill_nb_r31: got %h expected 31", nb_read_data2); end
        clear_req = 1'b1; reg_write = 1'b1; rd = 5'd5; write_data = 32'd9; #1;
        n_checks++; if (read_data1 !== 32'd5) begin n_fail++; $display("FAIL clrreq_no_bypass: got %h expected 5", read_data1); end
        @(posedge clk); #1;
        clear_req = 1'b0; reg_write = 1'b0; #1;
        n_checks++; if (wr_dropped !== 1'b1) begin n_fail++; $display("FAIL clrreq_wr_dropped: got %b expected 1", wr_dropped); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL clrreq_ready: got %b expected 0", ready); end
        cnt = 0;
        while (!ready && cnt < 100) begin
            @(posedge clk); #2; cnt++;
            if (!ready) begin
                n_checks++; if (read_data1 !== 32'h0) begin n_fail++; $display("FAIL clrreq_read cyc %0d: got %h expected 0", cnt, read_data1); end
            end
        end
        n_checks++; if (cnt !== 32) begin n_fail++; $display("FAIL clrreq_clear_len: got %0d expected 32", cnt); end
        for (int r = 0; r < 32; r++) begin
            rs1 = 5'(r); rs2 = 5'(31 - r); #1;
            n_checks++; if (read_data1 !== 32'h0) begin n_fail++; $display("FAIL cleared_rd1 r%0d: got %h expected 0", r, read_data1); end
            n_checks++; if (read_data2 !== 32'h0) begin n_fail++; $display("FAIL cleared_rd2 r%0d: got %h expected 0", 31 - r, read_data2); end
            n_checks++; if (nb_read_data1 !== 32'h0) begin n_fail++; $display("FAIL cleared_nb_rd1 r%0d: got %h expected 0", r, nb_read_data1); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid_clear;
        int cnt;
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL midclr_ready: got %b expected 0", ready); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; #1;
        cnt = 0;
        while (!ready && cnt < 100) begin
            @(posedge clk); #2; cnt++;
        end
        n_checks++; if (cnt !== 32) begin n_fail++; $display("FAIL midclr_clear_len: got %0d expected 32", cnt); end
        rs1 = 5'd31; rs2 = 5'd20; #1;
        n_checks++; if (read_data1 !== 32'h0) begin n_fail++; $display("FAIL midclr_rd1: got %h expected 0", read_data1); end
        n_checks++; if (read_data2 !== 32'h0) begin n_fail++; $display("FAIL midclr_rd2: got %h expected 0", read_data2); end
    endtask

    task automatic test_small;
        int cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; #1;
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL small_reset_ready: got %b expected 0", s_ready); end
        cnt = 0;
        while (!s_ready && cnt < 100) begin
            @(posedge clk); #2; cnt++;
        end
        n_checks++; if (cnt !== 8) begin n_fail++; $display("FAIL small_clear_len: got %0d expected 8", cnt); end
        s_reg_write = 1'b1; s_rd = 3'd7; s_write_data = 16'hA5A5; s_rs1 = 3'd0; s_rs2 = 3'd7; #1;
        n_checks++; if (s_read_data2 !== 16'hA5A5) begin n_fail++; $display("FAIL small_bypass_rd2: got %h expected a5a5", s_read_data2); end
        @(posedge clk); #1;
        s_reg_write = 1'b0; #1;
        n_checks++; if (s_read_data2 !== 16'hA5A5) begin n_fail++; $display("FAIL small_stored_rd2: got %h expected a5a5", s_read_data2); end
        n_checks++; if (s_read_data1 !== 16'h0000) begin n_fail++; $display("FAIL small_rd1_zero: got %h expected 0", s_read_data1); end
        n_checks++; if (s_wr_dropped !== 1'b0) begin n_fail++; $display("FAIL small_wr_dropped: got %b expected 0", s_wr_dropped); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_fill_clear();
        test_rst_mid_clear();
        test_small();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
